idct_8muladd: RTL and testbench

Inverse 8-point 1-D DCT engine, the decode-side counterpart of `dct_8muladd`. It accepts one packed vector of 8 signed DCT coefficients through a valid/ready handshake. Internal 8 multipliers and a fixed cosine ROM produce the 8 reconstructed samples. Samples leave serially, one per output handshake, with index and last flag, and feed the row/column transpose stage of the decoder path.

---
 rtl/idct_8muladd.sv | 113 +++++++++++
 tb/tb_idct_8muladd.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/idct_8muladd.sv
// idct_8muladd: 8-point inverse DCT, one coefficient vector in, eight samples out serially.
// Define IDCT_SAT_EN to clamp out-of-range samples instead of wrapping them.
module idct_8muladd #(
    parameter int DATA_WIDTH  = 32,
    parameter int DATA_DEPTH  = 8,
    parameter int FRAC_BITS   = 14,
    parameter int COEFF_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*DATA_DEPTH-1:0] data_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic [2:0]                       out_index,
    output logic                             out_last
);
    localparam int PW = DATA_WIDTH + COEFF_WIDTH;
    localparam int SW = PW + 3;
    localparam logic signed [SW-1:0] HALF = SW'(1) << (FRAC_BITS - 1);
    typedef enum logic [1:0] {IDLE, MUL, ADD, OUT} state_t;
    state_t state;
    logic signed [DATA_WIDTH-1:0] vec  [DATA_DEPTH];
    logic signed [PW-1:0]         prod [DATA_DEPTH];
    logic signed [SW-1:0]         sum;
    logic [DATA_WIDTH-1:0]        res;
    // The angle (2n+1)k*pi/16 is folded into the first quadrant; index 0 only occurs for k=0.
    function automatic logic signed [COEFF_WIDTH-1:0] rom(input logic [2:0] n, input logic [2:0] k);
        logic [6:0] p;
        logic [4:0] f;
        logic [4:0] j;
        logic       neg;
        logic signed [COEFF_WIDTH-1:0] mag;
        p   = {3'b0, n, 1'b1} * {4'b0, k};
        f   = p[4:0] > 5'd16 ? 5'd0 - p[4:0] : p[4:0];
        neg = f > 5'd8;
        j   = neg ? 5'd16 - f : f;
        case (j[3:0])
            4'd0:    mag = COEFF_WIDTH'(5793);
            4'd1:    mag = COEFF_WIDTH'(8035);
            4'd2:    mag = COEFF_WIDTH'(7568);
            4'd3:    mag = COEFF_WIDTH'(6811);
            4'd4:    mag = COEFF_WIDTH'(5793);
            4'd5:    mag = COEFF_WIDTH'(4551);
            4'd6:    mag = COEFF_WIDTH'(3135);
            4'd7:    mag = COEFF_WIDTH'(1598);
            default: mag = '0;
        endcase
        return neg ? -mag : mag;
    endfunction
`ifdef IDCT_SAT_EN
    localparam logic signed [SW-1:0] MAXV = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    logic signed [SW-1:0] rnd;
`endif
    always_comb begin
        sum = '0;
        for (int k = 0; k < DATA_DEPTH; k++) sum = sum + SW'(prod[k]);
`ifdef IDCT_SAT_EN
        rnd = (sum + HALF) >>> FRAC_BITS;
        res = rnd > MAXV ? MAXV[DATA_WIDTH-1:0] : rnd < MINV ? MINV[DATA_WIDTH-1:0] : rnd[DATA_WIDTH-1:0];
`else
        res = DATA_WIDTH'((sum + HALF) >>> FRAC_BITS);
`endif
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            data_out  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            for (int k = 0; k < DATA_DEPTH; k++) begin
                vec[k]  <= '0;
                prod[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    for (int k = 0; k < DATA_DEPTH; k++) vec[k] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
                    out_index <= '0;
                    in_ready  <= 1'b0;
                    state     <= MUL;
                end
                MUL: begin
                    for (int k = 0; k < DATA_DEPTH; k++) prod[k] <= PW'(vec[k]) * PW'(rom(out_index, 3'(k)));
                    state <= ADD;
                end
                ADD: begin
                    data_out  <= res;
                    out_valid <= 1'b1;
                    out_last  <= out_index == 3'd7;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    if (out_last) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        out_index <= out_index + 3'd1;
                        state     <= MUL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_idct_8muladd.sv
// tb_idct_8muladd: scoreboard bench for idct_8muladd against a floating-point-derived cosine model.
module tb_idct_8muladd;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] data_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  data_out;
    logic [2:0]   out_index;
    logic         out_last;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = 0;
    bit chk_busy = 1'b0;
    typedef struct {longint val; int idx;} exp_t;
    exp_t q[$];

    idct_8muladd dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .out_index(out_index), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint model(input logic [255:0] v, input int n);
        longint s = 0;
        longint c;
        longint r;
        real x;
        logic signed [31:0] w;
        for (int k = 0; k < 8; k++) begin
            x = 16384.0 * (k == 0 ? $sqrt(0.125) : 0.5) * $cos(real'((2*n+1)*k) * 3.14159265358979 / 16.0);
            c = longint'(x);
            s += longint'($signed(v[k*32 +: 32])) * c;
        end
        r = (s + 8192) >>> 14;
`ifdef IDCT_SAT_EN
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
`endif
        w = r[31:0];
        return longint'(w);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int busy = 0;
    int acc = 0;
    logic pv = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            busy = 0;
            pv = 1'b0;
        end else begin
            if (out_valid && !pv && out_index == 3'd0) chk("first_valid_latency", cyc - acc, 2);
            if (in_ready) begin
                if (busy > 0 && chk_busy) chk("in_ready_low_cycles", busy, 24);
                busy = 0;
                chk("idle_with_samples_pending", q.size(), 0);
            end else busy++;
            if (in_valid && in_ready) begin
                acc = cyc + 1;
                for (int n = 0; n < 8; n++) q.push_back('{model(data_in, n), n});
            end
            if (out_valid) begin
                chk("sample_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    chk("data_out", longint'($signed(data_out)), q[0].val);
                    chk("out_index", out_index, q[0].idx);
                    chk("out_last", out_last, q[0].idx == 7);
                    if (out_ready) void'(q.pop_front());
                end
            end
            pv = out_valid;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (mode == 0) out_ready = 1'b1;
        else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic send(input logic [255:0] v);
        int t = 0;
        in_valid = 1'b1;
        data_in = v;
        @(negedge clk);
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("send_accepted", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (!(in_ready && q.size() == 0 && !out_valid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", in_ready && q.size() == 0, 1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = 32'(int'($urandom_range(0, 2097150)) - 1048575);
        return v;
    endfunction

    logic [255:0] dc, x1, vmax;
    initial begin
        dc = '0;
        dc[31:0] = 32'd1000;
        x1 = '0;
        x1[63:32] = 32'd1000;
        vmax = {8{32'h7FFF_FFFF}};
        chk("model_dc_n0", model(dc, 0), 354);
        chk("model_dc_n5", model(dc, 5), 354);
        chk("model_x1_n0", model(x1, 0), 490);
        chk("model_x1_n7", model(x1, 7), -490);
`ifdef IDCT_SAT_EN
        chk("model_max_n0", model(vmax, 0), 2147483647);
`else
        chk("model_max_n0", model(vmax, 0), 1378353149);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_out_index", out_index, 0);
        chk("reset_out_last", out_last, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send(dc);
        in_valid = 1'b0;
        wait_idle();
        send(x1);
        in_valid = 1'b0;
        wait_idle();
        chk_busy = 1'b1;
        for (int i = 0; i < 4; i++) send(rand_vec());
        in_valid = 1'b0;
        wait_idle();
        chk_busy = 1'b0;
        mode = 1;
        for (int i = 0; i < 3; i++) send(rand_vec());
        in_valid = 1'b0;
        wait_idle();
        mode = 0;
        send(vmax);
        in_valid = 1'b0;
        wait_idle();
        mode = 2;
        out_ready = 1'b1;
        send(dc);
        in_valid = 1'b0;
        begin
            int t = 0;
            @(negedge clk);
            while (!(out_valid && out_index == 3'd3) && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("reached_index3", out_valid && out_index == 3'd3, 1);
        end
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_data_out", data_out, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mode = 0;
        out_ready = 1'b1;
        send(dc);
        in_valid = 1'b0;
        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
